greyscale_fb_scheduler: RTL and testbench

//  Ping-pong frame-buffer scheduler between the camera greyscale packer (6 px per 48-bit word) and a frame consumer.

---
 rtl/greyscale_fb_scheduler.sv | 215 +++++++++++++++++++++
 tb/tb_greyscale_fb_scheduler.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/greyscale_fb_scheduler.sv
// Ping-pong frame-buffer scheduler: gates packer writes into one BRAM bank and grants whole frames to the reader.
// Optional GREYSCALE_FB_STATS_EN enables the dropped/short frame counters (tied to zero otherwise).
module greyscale_fb_scheduler #(
  parameter int WORDS_PER_FRAME = 12800,
  parameter int ADDR_WIDTH      = 17,
  parameter int DATA_WIDTH      = 48,
  parameter int READ_LATENCY    = 2
) (
  input  logic                  clk_pixel,
  input  logic                  rst_in,
  input  logic                  wr_valid_in,
  input  logic [ADDR_WIDTH-1:0] wr_addr_in,
  input  logic [DATA_WIDTH-1:0] wr_data_in,
  input  logic                  frame_done_in,
  input  logic                  rd_start_in,
  input  logic                  rd_en_in,
  input  logic [ADDR_WIDTH-1:0] rd_addr_in,
  input  logic                  rd_done_in,
  input  logic [DATA_WIDTH-1:0] bram_rdata_in,
  output logic                  bram_wea_out,
  output logic [ADDR_WIDTH:0]   bram_waddr_out,
  output logic [DATA_WIDTH-1:0] bram_wdata_out,
  output logic [ADDR_WIDTH:0]   bram_raddr_out,
  output logic                  rd_grant_out,
  output logic                  frame_ready_out,
  output logic [DATA_WIDTH-1:0] rd_data_out,
  output logic                  rd_valid_out,
  output logic [15:0]           dropped_out,
  output logic [15:0]           short_out
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] FRAME_WORDS = CW'(WORDS_PER_FRAME);

  typedef enum logic [1:0] {B_FREE = 2'd0, B_FILLING = 2'd1, B_READY = 2'd2, B_READING = 2'd3} bank_st_e;
  typedef enum logic [1:0] {W_SYNC = 2'd0, W_FILL = 2'd1, W_HOLD = 2'd2} w_st_e;
  typedef enum logic {R_IDLE = 1'b0, R_ACTIVE = 1'b1} r_st_e;

  bank_st_e                bank_st_r  [0:1];
  bank_st_e                bank_eff_s [0:1];
  bank_st_e                bank_nxt_s [0:1];
  w_st_e                   w_state_r;
  r_st_e                   r_state_r;
  logic                    w_bank_r;
  logic                    rd_bank_r;
  logic [CW-1:0]           cnt_r;
  logic [CW-1:0]           cnt_inc_s;
  logic [READ_LATENCY:0]   vpipe_r;
  logic rd_act_s, grant_s, grant_bank_s, release_s, ob_s, accept_s, full_s;
  logic start_s, switch_s, hold_s, resume_s;

  assign rd_data_out  = bram_rdata_in;
  assign rd_valid_out = vpipe_r[READ_LATENCY];

  // Event decode: reader grant/release first, so the writer sees the post-reader view of the other bank
  always_comb begin
    rd_act_s     = (r_state_r == R_ACTIVE);
    grant_bank_s = (bank_st_r[0] == B_READY) ? 1'b0 : 1'b1;
    grant_s      = !rd_act_s && rd_start_in && ((bank_st_r[0] == B_READY) || (bank_st_r[1] == B_READY));
    release_s    = rd_act_s && rd_done_in;
    for (int i = 0; i < 2; i++) begin
      if (grant_s && (grant_bank_s == 1'(i))) begin
        bank_eff_s[i] = B_READING;
      end else if (release_s && (rd_bank_r == 1'(i))) begin
        bank_eff_s[i] = B_FREE;
      end else begin
        bank_eff_s[i] = bank_st_r[i];
      end
    end
    ob_s      = ~w_bank_r;
    accept_s  = (w_state_r == W_FILL) && wr_valid_in && ({1'b0, wr_addr_in} < FRAME_WORDS);
    if (accept_s && (cnt_r != {CW{1'b1}})) begin
      cnt_inc_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_inc_s = cnt_r;
    end
    full_s     = (cnt_inc_s == FRAME_WORDS);
    start_s    = 1'b0;
    switch_s   = 1'b0;
    hold_s     = 1'b0;
    resume_s   = 1'b0;
    bank_nxt_s = bank_eff_s;
    if (frame_done_in) begin
      case (w_state_r)
        W_SYNC: begin
          start_s              = 1'b1;
          bank_nxt_s[w_bank_r] = B_FILLING;
        end
        W_FILL: begin
          if (!full_s) begin
            bank_nxt_s[w_bank_r] = B_FILLING;
          end else if (bank_eff_s[ob_s] == B_READING) begin
            hold_s               = 1'b1;
            bank_nxt_s[w_bank_r] = B_READY;
          end else begin
            switch_s             = 1'b1;
            bank_nxt_s[w_bank_r] = B_READY;
            bank_nxt_s[ob_s]     = B_FILLING;
          end
        end
        W_HOLD: begin
          if (bank_eff_s[ob_s] == B_FREE) begin
            resume_s         = 1'b1;
            bank_nxt_s[ob_s] = B_FILLING;
          end else begin
            resume_s = 1'b0;
          end
        end
        default: begin
          start_s = 1'b0;
        end
      endcase
    end else begin
      start_s = 1'b0;
    end
  end

  // Writer FSM with registered BRAM write port
  always_ff @(posedge clk_pixel) begin
    if (rst_in) begin
      w_state_r      <= W_SYNC;
      w_bank_r       <= 1'b0;
      cnt_r          <= {CW{1'b0}};
      bram_wea_out   <= 1'b0;
      bram_waddr_out <= {(ADDR_WIDTH+1){1'b0}};
      bram_wdata_out <= {DATA_WIDTH{1'b0}};
    end else begin
      bram_wea_out <= accept_s;
      if (accept_s) begin
        bram_waddr_out <= {w_bank_r, wr_addr_in};
        bram_wdata_out <= wr_data_in;
      end
      cnt_r <= frame_done_in ? {CW{1'b0}} : cnt_inc_s;
      case (w_state_r)
        W_SYNC: if (start_s) w_state_r <= W_FILL;
        W_FILL: begin
          if (switch_s) begin
            w_bank_r <= ob_s;
          end else if (hold_s) begin
            w_state_r <= W_HOLD;
          end
        end
        W_HOLD: begin
          if (resume_s) begin
            w_bank_r  <= ob_s;
            w_state_r <= W_FILL;
          end
        end
        default: w_state_r <= W_SYNC;
      endcase
    end
  end

  // Reader FSM, bank ownership table and status flags
  always_ff @(posedge clk_pixel) begin
    if (rst_in) begin
      bank_st_r[0]    <= B_FREE;
      bank_st_r[1]    <= B_FREE;
      r_state_r       <= R_IDLE;
      rd_bank_r       <= 1'b0;
      rd_grant_out    <= 1'b0;
      frame_ready_out <= 1'b0;
    end else begin
      bank_st_r <= bank_nxt_s;
      case (r_state_r)
        R_IDLE: begin
          if (grant_s) begin
            r_state_r <= R_ACTIVE;
            rd_bank_r <= grant_bank_s;
          end
        end
        R_ACTIVE: if (release_s) r_state_r <= R_IDLE;
        default:  r_state_r <= R_IDLE;
      endcase
      rd_grant_out    <= grant_s || (rd_act_s && !release_s);
      frame_ready_out <= (bank_nxt_s[0] == B_READY) || (bank_nxt_s[1] == B_READY);
    end
  end

  // Read address register and valid pipeline matching the BRAM latency
  always_ff @(posedge clk_pixel) begin
    if (rst_in) begin
      bram_raddr_out <= {(ADDR_WIDTH+1){1'b0}};
      vpipe_r        <= {(READ_LATENCY+1){1'b0}};
    end else begin
      bram_raddr_out <= {rd_bank_r, rd_addr_in};
      vpipe_r        <= {vpipe_r[READ_LATENCY-1:0], rd_en_in && rd_act_s};
    end
  end

`ifdef GREYSCALE_FB_STATS_EN
  logic short_evt_s, drop_evt_s;

  // Statistic event decode
  always_comb begin
    short_evt_s = frame_done_in && (w_state_r == W_FILL) && !full_s;
    drop_evt_s  = switch_s && (bank_eff_s[ob_s] == B_READY);
  end

  // Saturating dropped/short frame counters
  always_ff @(posedge clk_pixel) begin
    if (rst_in) begin
      dropped_out <= 16'h0000;
      short_out   <= 16'h0000;
    end else begin
      if (drop_evt_s && (dropped_out != 16'hFFFF)) dropped_out <= dropped_out + 16'h0001;
      if (short_evt_s && (short_out != 16'hFFFF)) short_out <= short_out + 16'h0001;
    end
  end
`else
  assign dropped_out = 16'h0000;
  assign short_out   = 16'h0000;
`endif

endmodule

// File: tb/tb_greyscale_fb_scheduler.sv
// Directed bench for greyscale_fb_scheduler: a frame-ownership model plus literal spot checks.
module tb_greyscale_fb_scheduler;
  localparam int WPF = 4;
  localparam int AW  = 4;
  localparam int DW  = 48;
  localparam int RL  = 2;
`ifdef GREYSCALE_FB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk_pixel = 1'b0;
  logic rst_in, wr_valid_in, frame_done_in, rd_start_in, rd_en_in, rd_done_in;
  logic [AW-1:0] wr_addr_in, rd_addr_in;
  logic [DW-1:0] wr_data_in;
  logic [DW-1:0] bram_rdata = '0;
  logic [DW-1:0] bram_p1 = '0;
  logic          bram_wea_out, rd_grant_out, frame_ready_out, rd_valid_out;
  logic [AW:0]   bram_waddr_out, bram_raddr_out;
  logic [DW-1:0] bram_wdata_out, rd_data_out;
  logic [15:0]   dropped_out, short_out;

  greyscale_fb_scheduler #(.WORDS_PER_FRAME(WPF), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)) dut (
    .clk_pixel(clk_pixel), .rst_in(rst_in), .wr_valid_in(wr_valid_in), .wr_addr_in(wr_addr_in),
    .wr_data_in(wr_data_in), .frame_done_in(frame_done_in), .rd_start_in(rd_start_in),
    .rd_en_in(rd_en_in), .rd_addr_in(rd_addr_in), .rd_done_in(rd_done_in), .bram_rdata_in(bram_rdata),
    .bram_wea_out(bram_wea_out), .bram_waddr_out(bram_waddr_out), .bram_wdata_out(bram_wdata_out),
    .bram_raddr_out(bram_raddr_out), .rd_grant_out(rd_grant_out), .frame_ready_out(frame_ready_out),
    .rd_data_out(rd_data_out), .rd_valid_out(rd_valid_out), .dropped_out(dropped_out), .short_out(short_out)
  );

  initial forever #5 clk_pixel = ~clk_pixel;

  // Two-cycle BRAM: address register then output register
  logic [DW-1:0] bram_mem [0:(1<<(AW+1))-1];
  always @(posedge clk_pixel) begin
    if (bram_wea_out) bram_mem[bram_waddr_out] <= bram_wdata_out;
    bram_p1    <= bram_mem[bram_raddr_out];
    bram_rdata <= bram_p1;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int wea_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: which bank is being filled, which is ready, which the reader holds (-1 = none)
  int m_mode, m_wbank, m_ready, m_read, m_cnt, m_short, m_drop;
  logic [DW-1:0] m_mem [0:31];
  bit            vq_v [$];
  logic [DW-1:0] vq_d [$];
  bit            e_wea, e_rchk, e_grant, e_ready, e_valid;
  logic [AW:0]   e_waddr, e_raddr;
  logic [DW-1:0] e_wdata, e_rdata;
  logic [15:0]   e_drop, e_short;

  task automatic model_step();
    bit v;
    int other;
    if (rst_in) begin
      m_mode = 0; m_wbank = 0; m_ready = -1; m_read = -1; m_cnt = 0; m_short = 0; m_drop = 0;
      vq_v = {}; vq_d = {};
      vq_v.push_back(1'b0); vq_v.push_back(1'b0);
      vq_d.push_back('0); vq_d.push_back('0);
      e_wea = 1'b0; e_rchk = 1'b0; e_grant = 1'b0; e_ready = 1'b0; e_valid = 1'b0;
      e_drop = 16'h0; e_short = 16'h0;
      return;
    end
    v = (m_read >= 0) && rd_en_in;
    e_rchk = v;
    if (v) e_raddr = {m_read[0], rd_addr_in};
    vq_v.push_back(v);
    vq_d.push_back(v ? m_mem[{m_read[0], rd_addr_in}] : '0);
    e_valid = vq_v.pop_front();
    e_rdata = vq_d.pop_front();
    if (m_read < 0 && rd_start_in && m_ready >= 0) begin
      m_read = m_ready; m_ready = -1;
    end else if (m_read >= 0 && rd_done_in) begin
      m_read = -1;
    end
    e_wea = 1'b0;
    if (m_mode == 1 && wr_valid_in && int'(wr_addr_in) < WPF) begin
      e_wea = 1'b1; e_waddr = {m_wbank[0], wr_addr_in}; e_wdata = wr_data_in;
      m_mem[e_waddr] = wr_data_in;
      m_cnt++;
    end
    if (frame_done_in) begin
      other = 1 - m_wbank;
      if (m_mode == 0) begin
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (m_cnt != WPF) m_short++;
        else if (m_read == other) begin m_ready = m_wbank; m_mode = 2; end
        else begin
          if (m_ready == other) m_drop++;
          m_ready = m_wbank; m_wbank = other;
        end
      end else if (m_read != other && m_ready != other) begin
        m_wbank = other; m_mode = 1;
      end
      m_cnt = 0;
    end
    e_grant = (m_read >= 0);
    e_ready = (m_ready >= 0);
    e_drop  = STATS ? 16'((m_drop > 65535) ? 65535 : m_drop) : 16'h0;
    e_short = STATS ? 16'((m_short > 65535) ? 65535 : m_short) : 16'h0;
  endtask

  // Per-cycle comparison of every meaningful output against the model
  initial forever begin
    @(posedge clk_pixel);
    #1;
    chk("wea", 64'(bram_wea_out), 64'(e_wea));
    if (e_wea) begin
      chk("waddr", 64'(bram_waddr_out), 64'(e_waddr));
      chk("wdata", 64'(bram_wdata_out), 64'(e_wdata));
    end
    if (e_rchk) chk("raddr", 64'(bram_raddr_out), 64'(e_raddr));
    chk("grant", 64'(rd_grant_out), 64'(e_grant));
    chk("ready", 64'(frame_ready_out), 64'(e_ready));
    chk("valid", 64'(rd_valid_out), 64'(e_valid));
    if (e_valid) chk("rdata", 64'(rd_data_out), 64'(e_rdata));
    chk("dropped", 64'(dropped_out), 64'(e_drop));
    chk("short", 64'(short_out), 64'(e_short));
    if (bram_wea_out) wea_seen++;
  end

  task automatic tick();
    model_step();
    @(posedge clk_pixel);
    #3;
    wr_valid_in = 1'b0; frame_done_in = 1'b0; rd_start_in = 1'b0; rd_en_in = 1'b0; rd_done_in = 1'b0;
  endtask

  function automatic logic [DW-1:0] word(input int fid, input int a);
    return {16'hA5A5, 16'h0000, fid[7:0], a[7:0]};
  endfunction

  task automatic write_frame(input int n, input int fid);
    for (int a = 0; a < n; a++) begin
      wr_valid_in = 1'b1; wr_addr_in = AW'(a); wr_data_in = word(fid, a);
      tick();
    end
  endtask

  task automatic read_word(input int addr, input logic [DW-1:0] exp, input string name);
    int lat;
    lat = 0;
    rd_en_in = 1'b1; rd_addr_in = AW'(addr);
    do begin
      tick();
      lat++;
    end while (!rd_valid_out && lat < 8);
    chk({name, "_lat"}, 64'(lat), 64'd3);
    chk({name, "_data"}, 64'(rd_data_out), 64'(exp));
  endtask

  task automatic done_tick();
    frame_done_in = 1'b1;
    tick();
  endtask

  initial begin
    int w0;
    rst_in = 1'b1; wr_valid_in = 1'b0; frame_done_in = 1'b0; rd_start_in = 1'b0;
    rd_en_in = 1'b0; rd_done_in = 1'b0; wr_addr_in = '0; rd_addr_in = '0; wr_data_in = '0;
    repeat (3) tick();
    rst_in = 1'b0;
    chk("reset_ready", 64'(frame_ready_out), 64'd0);
    chk("reset_grant", 64'(rd_grant_out), 64'd0);
    rd_start_in = 1'b1; rd_en_in = 1'b1;
    tick();
    chk("start_no_ready", 64'(rd_grant_out), 64'd0);

    // First frame after reset is discarded
    write_frame(4, 1);
    done_tick();
    chk("sync_drop", 64'(wea_seen), 64'd0);
    w0 = wea_seen;
    write_frame(4, 2);
    chk("fill_writes", 64'(wea_seen - w0), 64'd4);
    chk("fill_bank0", 64'(bram_waddr_out[AW]), 64'd0);
    done_tick();
    chk("frame_ready", 64'(frame_ready_out), 64'd1);

    rd_start_in = 1'b1;
    tick();
    chk("grant", 64'(rd_grant_out), 64'd1);
    chk("ready_taken", 64'(frame_ready_out), 64'd0);
    read_word(2, 48'hA5A5_0000_0202, "read_b0");

    // Writer completes bank 1 while reader holds bank 0
    write_frame(4, 3);
    done_tick();
    chk("hold_ready", 64'(frame_ready_out), 64'd1);
    w0 = wea_seen;
    write_frame(4, 4);
    chk("hold_drop", 64'(wea_seen - w0), 64'd0);
    rd_done_in = 1'b1; frame_done_in = 1'b1;
    tick();
    chk("release", 64'(rd_grant_out), 64'd0);
    write_frame(4, 5);
    chk("resume_bank0", 64'(bram_waddr_out[AW]), 64'd0);

    // Overwrite of the unread ready frame
    done_tick();
    chk("dropped", 64'(dropped_out), STATS ? 64'd1 : 64'd0);
    chk("ready_newest", 64'(frame_ready_out), 64'd1);
    rd_start_in = 1'b1;
    tick();
    chk("grant_newest", 64'(rd_grant_out), 64'd1);
    read_word(1, 48'hA5A5_0000_0501, "read_newest");
    rd_done_in = 1'b1;
    tick();

    // Short frame
    write_frame(3, 6);
    done_tick();
    chk("short", 64'(short_out), STATS ? 64'd1 : 64'd0);
    chk("short_ready", 64'(frame_ready_out), 64'd0);
    write_frame(4, 7);
    done_tick();

    // Out-of-range address, then simultaneous grant and frame_done
    w0 = wea_seen;
    wr_valid_in = 1'b1; wr_addr_in = 4'd4; wr_data_in = word(99, 4);
    tick();
    chk("addr_oob", 64'(wea_seen - w0), 64'd0);
    write_frame(4, 8);
    rd_start_in = 1'b1; frame_done_in = 1'b1;
    tick();
    chk("simul_grant", 64'(rd_grant_out), 64'd1);
    chk("simul_ready", 64'(frame_ready_out), 64'd1);
    read_word(3, 48'hA5A5_0000_0703, "read_old");
    w0 = wea_seen;
    write_frame(2, 9);
    chk("simul_hold_drop", 64'(wea_seen - w0), 64'd0);
    rd_done_in = 1'b1;
    tick();
    done_tick();
    write_frame(1, 10);
    chk("resume_bank1", 64'(bram_waddr_out[AW]), 64'd1);
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
